bram_cam_arb: RTL

//  Access controller for one bram_unit (single-port, NO_CHANGE, LOW_LATENCY) in the CAM-on-BRAM array.
//  - Clears the whole BRAM after reset or on request.
//  - Arbitrates a search (read) port and an update (masked write) port onto the single BRAM port.
//  - Returns search data with fixed 1-cycle latency.
//  - Sits between the CAM key/update logic and the BRAM storage column.

---
 rtl/bram_cam_arb_pkg.sv | 10 +
 rtl/bram_cam_arb_if.sv | 28 ++
 rtl/bram_cam_arb_unit.sv | 34 +++
 rtl/bram_cam_arb.sv | 110 +++++++++++
 4 files changed

// File: rtl/bram_cam_arb_pkg.sv
// Shared types and default geometry for the CAM-on-BRAM access controller.
package cam_bram_pkg;

  typedef enum logic {S_INIT, S_RUN} arb_state_t;

  localparam int BRAM_DEPTH_DEF = 512;
  localparam int BRAM_WIDTH_DEF = 64;
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/bram_cam_arb_if.sv
// Search/update/init handshake bundle between CAM key logic and the BRAM arbiter.
interface bram_cam_arb_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 64
);
  logic              init_start;
  logic              init_busy;
  logic              srch_valid;
  logic              srch_ready;
  logic [ADDR_W-1:0] srch_addr;
  logic              srch_rvalid;
  logic [DATA_W-1:0] srch_rdata;
  logic              upd_valid;
  logic              upd_ready;
  logic [ADDR_W-1:0] upd_addr;
  logic [DATA_W-1:0] upd_wdata;
  logic [DATA_W-1:0] upd_mask;

  modport master (
    output init_start, srch_valid, srch_addr, upd_valid, upd_addr, upd_wdata, upd_mask,
    input  init_busy, srch_ready, srch_rvalid, srch_rdata, upd_ready
  );

  modport slave (
    input  init_start, srch_valid, srch_addr, upd_valid, upd_addr, upd_wdata, upd_mask,
    output init_busy, srch_ready, srch_rvalid, srch_rdata, upd_ready
  );
endinterface

// File: rtl/bram_cam_arb_unit.sv
// Single-port BRAM, NO_CHANGE write mode, LOW_LATENCY (1-cycle read), bit-masked writes.
module bram_unit
  import cam_bram_pkg::*;
#(
  parameter int BRAM_DEPTH = BRAM_DEPTH_DEF,
  parameter int BRAM_WIDTH = BRAM_WIDTH_DEF,
  localparam int ADDR_W    = $clog2(BRAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  chip_en,
  input  logic                  wr_en,
  input  logic                  reg_en,
  input  logic                  bram_rst,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [BRAM_WIDTH-1:0] wdata,
  input  logic [BRAM_WIDTH-1:0] mask,
  output logic [BRAM_WIDTH-1:0] rdata
);

  logic [BRAM_WIDTH-1:0] mem [BRAM_DEPTH];

  // Writes leave rdata untouched (NO_CHANGE); only reads refresh it.
  always_ff @(posedge clk) begin
    if (chip_en && wr_en) begin
      mem[addr] <= (mem[addr] & ~mask) | (wdata & mask);
    end
    if (bram_rst) begin
      rdata <= '0;
    end else if (chip_en && !wr_en && reg_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bram_cam_arb.sv
// BRAM access controller: post-reset/on-demand clear walk plus search/update arbitration
// with bounded search priority so a waiting update is never starved.
module bram_cam_arb
  import cam_bram_pkg::*;
#(
  parameter int BRAM_DEPTH = BRAM_DEPTH_DEF,
  parameter int BRAM_WIDTH = BRAM_WIDTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  localparam int ADDR_W    = $clog2(BRAM_DEPTH)
) (
  input logic           clk,
  input logic           rst,
  bram_cam_arb_if.slave bus
);

  arb_state_t            state, state_nxt;
  logic [ADDR_W-1:0]     clr_addr, clr_addr_nxt;
  logic [3:0]            starve_cnt, starve_cnt_nxt;
  logic                  srch_rvalid_q;

  logic                  srch_gnt, upd_gnt;
  logic                  bram_ce, bram_we;
  logic [ADDR_W-1:0]     bram_addr;
  logic [BRAM_WIDTH-1:0] bram_wdata, bram_mask, bram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_INIT;
      clr_addr      <= '0;
      starve_cnt    <= '0;
      srch_rvalid_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      clr_addr      <= clr_addr_nxt;
      starve_cnt    <= starve_cnt_nxt;
      srch_rvalid_q <= srch_gnt;
    end
  end

  always_comb begin
    state_nxt      = state;
    clr_addr_nxt   = clr_addr;
    starve_cnt_nxt = '0;
    srch_gnt       = 1'b0;
    upd_gnt        = 1'b0;
    bram_ce        = 1'b0;
    bram_we        = 1'b0;
    bram_addr      = bus.upd_addr;
    bram_wdata     = bus.upd_wdata;
    bram_mask      = bus.upd_mask;

    unique case (state)
      S_INIT: begin
        bram_ce    = 1'b1;
        bram_we    = 1'b1;
        bram_addr  = clr_addr;
        bram_wdata = '0;
        bram_mask  = '1;
        if (clr_addr == ADDR_W'(BRAM_DEPTH - 1)) begin
          state_nxt    = S_RUN;
          clr_addr_nxt = '0;
        end else begin
          clr_addr_nxt = clr_addr + ADDR_W'(1);
        end
      end
      S_RUN: begin
        srch_gnt = bus.srch_valid &&
                   (!bus.upd_valid || (starve_cnt != 4'(STARVE_MAX)));
        upd_gnt  = bus.upd_valid && !srch_gnt;
        if (srch_gnt) begin
          bram_ce   = 1'b1;
          bram_addr = bus.srch_addr;
        end else if (upd_gnt) begin
          bram_ce = 1'b1;
          bram_we = 1'b1;
        end
        // Counts consecutive search wins only while an update is actually waiting.
        if (bus.upd_valid && srch_gnt) begin
          starve_cnt_nxt = starve_cnt + 4'd1;
        end
        if (bus.init_start) begin
          state_nxt = S_INIT;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  assign bus.init_busy   = (state == S_INIT);
  assign bus.srch_ready  = srch_gnt;
  assign bus.upd_ready   = upd_gnt;
  assign bus.srch_rvalid = srch_rvalid_q;
  assign bus.srch_rdata  = bram_rdata;

  bram_unit #(
    .BRAM_DEPTH (BRAM_DEPTH),
    .BRAM_WIDTH (BRAM_WIDTH)
  ) u_bram (
    .clk      (clk),
    .chip_en  (bram_ce),
    .wr_en    (bram_we),
    .reg_en   (1'b1),
    .bram_rst (1'b0),
    .addr     (bram_addr),
    .wdata    (bram_wdata),
    .mask     (bram_mask),
    .rdata    (bram_rdata)
  );

endmodule
